// File: rtl/arith_ext_ctrl.sv
// arith_ext_ctrl: round-robin arbiter feeding one shared 8x8 multiplier for single-cycle MUL and iterative integer SQRT
module arith_ext_ctrl #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic       req_op0,
  input  logic       req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_b1,
  input  logic       flush,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_id,
  output logic [7:0] res_hi,
  output logic [7:0] res_lo,
  output logic       res_carry,
  output logic       res_exact,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, MUL, SQRT, DONE} state_t;
  state_t state, state_nx;
  logic prio, grant, accept, op_in, sq_done;
  logic [7:0] a, b, sq, mul_x, mul_y, p;
  logic [3:0] r;
  logic [4:0] r_inc;
  logic [15:0] product;
  assign grant = (req_valid == 2'b11) ? prio : req_valid[1];
  assign req_ready = (state == IDLE && !flush && rst_n && req_valid != 2'b00) ? (2'b01 << grant) : 2'b00;
  assign accept = |(req_valid & req_ready);
  assign op_in = grant ? req_op1 : req_op0;
  assign r_inc = {1'b0, r} + 5'd1;
  assign mul_x = (state == SQRT) ? {3'b000, r_inc} : a;
  assign mul_y = (state == SQRT) ? {3'b000, r_inc} : b;
  assign product = {8'h00, mul_x} * {8'h00, mul_y};
  assign p = product[7:0];
  assign sq_done = (r == 4'd15) || (p > a);
  assign res_valid = (state == DONE);
  assign busy = (state != IDLE);
  // Next-state selection; flush overrides every other transition
  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else if (state == IDLE) state_nx = accept ? (op_in ? SQRT : MUL) : IDLE;
    else if (state == MUL) state_nx = DONE;
    else if (state == SQRT) state_nx = sq_done ? DONE : SQRT;
    else state_nx = res_ready ? IDLE : DONE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Operand capture, square-root search and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio <= RR_INIT;
      a <= '0;
      b <= '0;
      r <= '0;
      sq <= '0;
      res_id <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      res_carry <= 1'b0;
      res_exact <= 1'b0;
    end else begin
      if (accept) begin
        a <= grant ? req_a1 : req_a0;
        b <= grant ? req_b1 : req_b0;
        res_id <= grant;
        prio <= ~grant;
        r <= '0;
        sq <= '0;
      end
      if (state == MUL) begin
        res_hi <= product[15:8];
        res_lo <= product[7:0];
        res_carry <= |product[15:8];
        res_exact <= 1'b0;
      end
      if (state == SQRT) begin
        if (sq_done) begin
          res_hi <= '0;
          res_lo <= {4'h0, r};
          res_carry <= 1'b0;
          res_exact <= (sq == a);
        end else begin
          r <= r_inc[3:0];
          sq <= p;
        end
      end
    end
endmodule

// File: tb/tb_arith_ext_ctrl.sv
// tb_arith_ext_ctrl: randomized self-checking bench for arith_ext_ctrl against a transaction-level model
module tb_arith_ext_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic req_op0 = 1'b0, req_op1 = 1'b0;
  logic [7:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic flush = 1'b0;
  logic res_valid, res_ready = 1'b0, res_id, res_carry, res_exact, busy;
  logic [7:0] res_hi, res_lo;
  logic prio_m = 1'b0;
  int checks = 0;
  int errors = 0;
  arith_ext_ctrl #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .flush(flush), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .res_hi(res_hi), .res_lo(res_lo),
    .res_carry(res_carry), .res_exact(res_exact), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // fl: 0 normal, >0 flush at that cycle after accept, <0 flush together with res_ready in DONE
  task automatic run_op(input logic [1:0] v, input logic o0, input logic o1, input logic [7:0] a0,
                        input logic [7:0] b0, input logic [7:0] a1, input logic [7:0] b1,
                        input int hold, input int fl);
    logic g, eo, ec, ex, seen;
    logic [7:0] ea, eb, eh, el;
    logic [15:0] prod;
    int s, lat, n;
    @(negedge clk);
    req_valid = v; req_op0 = o0; req_op1 = o1;
    req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1; res_ready = 1'b0;
    #1;
    g = (v == 2'b11) ? prio_m : v[1];
    check("grant", {30'b0, req_ready}, g ? 32'd2 : 32'd1);
    eo = g ? o1 : o0;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    if (eo) begin
      s = 0;
      while ((s + 1) * (s + 1) <= int'(ea)) s++;
      eh = 8'h00; el = 8'(s); ec = 1'b0; ex = (s * s == int'(ea));
      lat = 1 + (s > 15 ? 15 : s) + 1;
    end else begin
      prod = ea * eb;
      eh = prod[15:8]; el = prod[7:0]; ec = |prod[15:8]; ex = 1'b0;
      lat = 2;
    end
    @(posedge clk);
    prio_m = ~g;
    if (fl > 0) begin
      repeat (fl) @(negedge clk);
      req_valid = 2'b11; flush = 1'b1;
      @(negedge clk);
      check("flush_idle", {29'b0, req_ready, busy}, 32'd0);
      flush = 1'b0; req_valid = 2'b00;
      seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        seen = seen | res_valid | busy;
      end
      check("flush_quiet", {31'b0, seen}, 32'd0);
      return;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 40);
    check("latency", n, lat);
    check("result", {10'b0, res_valid, res_id, res_hi, res_lo, res_carry, res_exact, req_ready},
          {10'b0, 1'b1, g, eh, el, ec, ex, 2'b00});
    if (fl < 0) begin
      flush = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      check("flush_done", {30'b0, res_valid, busy}, 32'd0);
      flush = 1'b0; res_ready = 1'b0; req_valid = 2'b00;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold", {10'b0, res_valid, res_id, res_hi, res_lo, res_carry, res_exact, req_ready},
            {10'b0, 1'b1, g, eh, el, ec, ex, 2'b00});
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("release", {30'b0, res_valid, busy}, 32'd0);
    res_ready = 1'b0; req_valid = 2'b00;
  endtask
  initial begin
    req_valid = 2'b11;
    #1;
    check("reset_out", {10'b0, res_valid, busy, req_ready, res_id, res_hi, res_lo, res_carry, res_exact}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b01, 1'b0, 1'b0, 8'h10, 8'h20, 8'h00, 8'h00, 5, 0);
    run_op(2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'd16, 8'h55, 0, 0);
    run_op(2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'd17, 8'h00, 1, 0);
    run_op(2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'd0, 8'h00, 0, 0);
    run_op(2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'd255, 8'h00, 2, 0);
    for (int i = 0; i < 4; i++)
      run_op(2'b11, 1'b0, 1'b0, 8'(i + 3), 8'h11, 8'(i + 40), 8'h07, 0, 0);
    run_op(2'b01, 1'b1, 1'b0, 8'd100, 8'h00, 8'h00, 8'h00, 0, 0);
    run_op(2'b01, 1'b0, 1'b0, 8'hff, 8'hff, 8'h00, 8'h00, 0, 0);
    run_op(2'b10, 1'b0, 1'b1, 8'h00, 8'h00, 8'd200, 8'h00, 0, 3);
    run_op(2'b11, 1'b0, 1'b0, 8'h02, 8'h03, 8'h04, 8'h05, 0, 0);
    run_op(2'b01, 1'b0, 1'b0, 8'h81, 8'h03, 8'h00, 8'h00, 0, -1);
    run_op(2'b11, 1'b1, 1'b1, 8'd49, 8'h00, 8'd50, 8'h00, 0, 0);
    @(negedge clk);
    req_valid = 2'b01; req_op0 = 1'b1; req_a0 = 8'd255;
    @(posedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid", {10'b0, res_valid, busy, req_ready, res_id, res_hi, res_lo, res_carry, res_exact}, 32'd0);
    prio_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b00;
    run_op(2'b11, 1'b0, 1'b0, 8'h07, 8'h09, 8'h0b, 8'h0d, 0, 0);
    for (int i = 0; i < 60; i++)
      run_op(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? -1 : 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
